// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single combinational ALU between two requesters: port 0 is the
// pipeline EX stage and port 1 is an auxiliary engine. Requesters are granted
// round-robin, at most one per cycle. Each requester has one registered
// response slot that holds its last ALU result.
//
// Parameters
//   WIDTH : operand/result width
//   OPW   : ALU function-code width
//   CNTW  : width of the saturating conflict counter
//
// Ports
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   req<i>_valid/ready      : request handshake for requester i
//   req<i>_a/b/aluc         : operands and undecoded ALU function code
//   rsp<i>_valid/ready/data : registered result handshake for requester i
//   alu_a/alu_b/alu_c       : operands and function code driven to the ALU
//   alu_result              : ALU output, captured on the accept edge
//   prio                    : requester that wins the next conflict
//   conflict_cnt            : cycles with both requesters eligible, saturating
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 6,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_aluc,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_aluc,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_c,
  input  logic [WIDTH-1:0] alu_result,

  output logic             prio,
  output logic [CNTW-1:0]  conflict_cnt
);

  // Function code presented to the ALU when nobody is granted.
  localparam logic [OPW-1:0] ALU_ADD = OPW'(6'b100000);

  logic elig0, elig1;
  logic grant0, grant1;
  logic conflict;

  // A requester may issue when its response slot is free, or is being
  // drained this same cycle, so a consumer that keeps rsp_ready high sees
  // one result per cycle.
  assign elig0    = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1    = req1_valid & (~rsp1_valid | rsp1_ready);
  assign conflict = elig0 & elig1;

  // prio only breaks ties; a lone eligible requester always wins. Reset
  // masks both grants so nothing presented during reset is accepted.
  assign grant0 = ~reset & elig0 & (~elig1 | ~prio);
  assign grant1 = ~reset & elig1 & (~elig0 |  prio);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value held and infers a latch.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_c = ALU_ADD;
    if (grant0) begin
      alu_a = req0_a;
      alu_b = req0_b;
      alu_c = req0_aluc;
    end else if (grant1) begin
      alu_a = req1_a;
      alu_b = req1_b;
      alu_c = req1_aluc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= '0;
      prio         <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      // A new grant wins over release, so consume-and-reissue keeps the
      // slot valid and simply replaces the data.
      if (grant0) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= alu_result;
      end else if (rsp0_valid && rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end

      if (grant1) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= alu_result;
      end else if (rsp1_valid && rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end

      // The loser of this cycle gets priority next time.
      if (grant0) begin
        prio <= 1'b1;
      end else if (grant1) begin
        prio <= 1'b0;
      end

      if (conflict && (conflict_cnt != {CNTW{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small behavioural ALU closes the loop on
// the ALU ports. A second instance with CNTW=2 shares the request stimulus so
// conflict counter saturation can be observed alongside the main instance.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled 1 unit later and registered outputs 1 unit after the next edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 6;
  localparam int CNTW  = 16;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;

  logic             clk;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_aluc, req1_aluc;
  logic             rsp0_ready, rsp1_ready;

  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_c;
  logic             prio;
  logic [CNTW-1:0]  conflict_cnt;

  logic             s_req0_ready, s_req1_ready;
  logic             s_rsp0_valid, s_rsp1_valid;
  logic [WIDTH-1:0] s_rsp0_data, s_rsp1_data;
  logic [WIDTH-1:0] s_alu_a, s_alu_b, s_alu_result;
  logic [OPW-1:0]   s_alu_c;
  logic             s_prio;
  logic [1:0]       s_conflict_cnt;

  int checks   = 0;
  int failures = 0;

  function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [OPW-1:0]   c);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return '0;
    endcase
  endfunction

  assign alu_result   = alu_model(alu_a, alu_b, alu_c);
  assign s_alu_result = alu_model(s_alu_a, s_alu_b, s_alu_c);

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_result(alu_result),
    .prio(prio), .conflict_cnt(conflict_cnt)
  );

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(2)) u_sat (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .rsp0_valid(s_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(s_rsp0_data),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .rsp1_valid(s_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(s_rsp1_data),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_c(s_alu_c), .alu_result(s_alu_result),
    .prio(s_prio), .conflict_cnt(s_conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluc = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_aluc = OP_ADD;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_aluc = OP_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    tick();
    tick();
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b%b expected 00", rsp0_valid, rsp1_valid);
    end
    checks++;
    if (rsp0_data !== 32'd0 || rsp1_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: got %0h/%0h expected 0/0", rsp0_data, rsp1_data);
    end
    checks++;
    if (prio !== 1'b0 || conflict_cnt !== 16'd0 || s_conflict_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_prio_cnt: got prio=%b cnt=%0d scnt=%0d expected 0 0 0",
               prio, conflict_cnt, s_conflict_cnt);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_aluc = OP_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: got %b%b expected 10", req0_ready, req1_ready);
    end
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_c !== OP_ADD) begin
      failures++;
      $display("FAIL single_alu_drive: got %0h %0h %b expected 5 3 100000",
               alu_a, alu_b, alu_c);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd8 || rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got v0=%b d0=%0d v1=%b expected 1 8 0",
               rsp0_valid, rsp0_data, rsp1_valid);
    end
    checks++;
    if (prio !== 1'b1) begin
      failures++;
      $display("FAIL single_prio: got %b expected 1", prio);
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp0_data !== 32'd8) begin
      failures++;
      $display("FAIL single_release: got v0=%b d0=%0d expected 0 8", rsp0_valid, rsp0_data);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant;
    pulse_reset();
    req0_valid = 1'b1; req0_a = 32'd10;   req0_b = 32'd4;    req0_aluc = OP_SUB;
    req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h3C;   req1_aluc = OP_AND;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_grant = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== exp_grant) begin
        failures++;
        $display("FAIL contention_grant[%0d]: got %b%b expected %b",
                 i, req0_ready, req1_ready, exp_grant);
      end
      @(posedge clk);
      #1;
      checks++;
      if (conflict_cnt !== 16'(i + 1)) begin
        failures++;
        $display("FAIL contention_cnt[%0d]: got %0d expected %0d", i, conflict_cnt, i + 1);
      end
      checks++;
      if (s_conflict_cnt !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1))) begin
        failures++;
        $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, s_conflict_cnt,
                 (i + 1 > 3) ? 3 : i + 1);
      end
      #(-1 + 1);
    end
    checks++;
    if (rsp0_data !== 32'd6 || rsp1_data !== 32'h30) begin
      failures++;
      $display("FAIL contention_data: got %0h/%0h expected 6/30", rsp0_data, rsp1_data);
    end
    // Idle cycle: ALU sees the default ADD of zeros.
    idle_inputs();
    #1;
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_c !== OP_ADD ||
        req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_alu: got a=%0h b=%0h c=%b rdy=%b%b expected 0 0 100000 00",
               alu_a, alu_b, alu_c, req0_ready, req1_ready);
    end
    tick();
    checks++;
    if (prio !== 1'b1 || conflict_cnt !== 16'd5 || s_conflict_cnt !== 2'd3) begin
      failures++;
      $display("FAIL idle_hold: got prio=%b cnt=%0d scnt=%0d expected 1 5 3",
               prio, conflict_cnt, s_conflict_cnt);
    end
  endtask

  task automatic test_backpressure();
    pulse_reset();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_aluc = OP_OR;
    tick();
    req0_a = 32'd7; req0_b = 32'd9; req0_aluc = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready[%0d]: got %b expected 0", i, req0_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd3) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d expected 1 3", i, rsp0_valid, rsp0_data);
      end
      #(-1 + 1);
    end
    rsp0_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_same_cycle_ready: got %b expected 1", req0_ready);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd16) begin
      failures++;
      $display("FAIL bp_reissue: got v=%b d=%0d expected 1 16", rsp0_valid, rsp0_data);
    end
  endtask

  task automatic test_blocked_yield();
    pulse_reset();
    // Fill slot 0 (prio -> 1), then slot 1 alone (prio -> 0).
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_aluc = OP_ADD;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd1; req1_aluc = OP_SUB;
    tick();
    checks++;
    if (prio !== 1'b0 || rsp0_valid !== 1'b1 || rsp1_valid !== 1'b1) begin
      failures++;
      $display("FAIL yield_setup: got prio=%b v=%b%b expected 0 11", prio, rsp0_valid, rsp1_valid);
    end
    // Both valid, slot 0 blocked: requester 1 wins despite prio=0.
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_aluc = OP_ADD;
    req1_a = 32'd4; req1_b = 32'd4; req1_aluc = OP_ADD;
    rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL yield_grant: got %b%b expected 01", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (prio !== 1'b0 || rsp1_data !== 32'd8 || rsp0_data !== 32'd4 || conflict_cnt !== 16'd0) begin
      failures++;
      $display("FAIL yield_after: got prio=%b d1=%0d d0=%0d cnt=%0d expected 0 8 4 0",
               prio, rsp1_data, rsp0_data, conflict_cnt);
    end
    // Drain slot 0 via a lone grant to 0 so prio becomes 1, slot 1 stays full.
    req1_valid = 1'b0; rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midop();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b1 || prio !== 1'b1) begin
      failures++;
      $display("FAIL midop_setup: got v=%b%b prio=%b expected 11 1", rsp0_valid, rsp1_valid, prio);
    end
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL midop_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_data !== 32'd0 ||
        rsp1_data !== 32'd0 || prio !== 1'b0 || conflict_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midop_cleared: got v=%b%b d=%0h/%0h prio=%b cnt=%0d expected 00 0/0 0 0",
               rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, prio, conflict_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_blocked_yield();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
